add_sub_sub_sched: RTL
======================

Name: add_sub_sub_sched

Overview:
- Byte-serial subtract scheduler for the FPU add/sub path.
- Shares a single 8-bit borrow-chained subtract slice between two requesters, e.g. the real and imaginary butterfly exponent/mantissa paths of the FFT.
- Each accepted request is a DATA_W-bit subtraction. It runs one byte per cycle, least-significant byte first, and the borrow is carried in a register.
- The result is returned on a valid/ready output tagged with the requester ID.

Parameters:
- DATA_W, 32, operand width in bits; must be a multiple of 8 and at least 8.
- NUM_BYTES, DATA_W/8, derived localparam; number of RUN cycles.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous reset, active-high.
- i_req0_valid  input  1  requester 0 has an operation pending.
- o_req0_ready  output  1  requester 0 is accepted this cycle.
- i_req0_a  input  DATA_W  minuend, requester 0.
- i_req0_b  input  DATA_W  subtrahend, requester 0.
- i_req0_bin  input  1  borrow-in, requester 0.
- i_req1_valid, o_req1_ready, i_req1_a, i_req1_b, i_req1_bin: same as requester 0, for requester 1.
- o_res_valid  output  1  result available.
- i_res_ready  input  1  consumer accepts the result.
- o_res_diff  output  DATA_W  (a - b - bin) mod 2^DATA_W.
- o_res_borrow  output  1  1 iff a < b + bin (unsigned).
- o_res_id  output  1  requester that issued the result.
- o_busy  output  1  state is not IDLE.

Behaviour:
- Clock and reset: single clock i_clk. i_rst is synchronous, active-high, and sampled on the rising edge.
- Reset values:
  - state = IDLE; byte counter = 0; borrow register = 0; result register = 0.
  - Round-robin pointer = 0 (requester 0 has priority).
  - o_res_valid = 0, o_res_diff = 0, o_res_borrow = 0, o_res_id = 0, o_busy = 0.
  - Both ready outputs = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Grant logic is combinational from the valids and the pointer.
  - If only one valid is high, that requester is granted. If both are high, the requester selected by the pointer is granted.
  - Exactly the granted requester's ready goes high. The handshake completes when valid & ready are both high.
  - On the handshake edge, latch a, b, bin and id. The borrow register loads bin, the counter loads 0, and the state goes to RUN.
  - With no valid, the block stays in IDLE and both readies stay 0.
- RUN, one cycle per byte k = counter:
  - The slice computes a[8k+7:8k] - b[8k+7:8k] - borrow_reg.
  - The 8-bit difference is written into result byte k, and the borrow register takes the slice borrow-out.
  - The counter increments. When k = NUM_BYTES-1, the state goes to DONE and o_res_valid is registered high.
- DONE:
  - o_res_diff, o_res_borrow (the final borrow register) and o_res_id are held stable while o_res_valid=1.
  - When i_res_ready=1, go to IDLE, clear o_res_valid, and set the pointer to the non-served requester.
  - No request is accepted in DONE.
- Ready outputs are 0 in RUN and DONE. Request inputs are don't-care when not granted.
- Latency:
  - If the accept edge is at cycle T, o_res_valid is high from cycle T+NUM_BYTES+1; that is cycle T+5 for DATA_W=32.
  - Best-case issue interval is NUM_BYTES+2 cycles.
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Reset mid-operation (RUN or DONE): the operation is abandoned, no result is emitted, and all registers return to their reset values on the next edge.
- Arithmetic: unsigned modular subtraction throughout. bin=1 with a=b gives all-ones and borrow=1.

Decomposition:
- Package add_sub_sched_pkg contains:
  - enum state_t {IDLE, RUN, DONE};
  - localparam BYTE_W = 8;
  - typedef logic req_id_t.
- Sub-module add_sub_sched_slice: purely combinational 8-bit a - b - bin with borrow-out. It is instantiated once and driven by the byte mux.
- The controller (FSM, arbiter, counter, result register) stays in add_sub_sub_sched.

Test Plan:
- Basic: only req0, a=0x00000005, b=0x00000003, bin=0. Required: o_req0_ready=1 in the accept cycle, o_res_valid=1 five cycles later, diff=0x00000002, borrow=0, id=0.
- Full borrow chain: req1, a=0x00000000, b=0x00000001, bin=0. Required: diff=0xFFFFFFFF, borrow=1, id=1.
- Borrow-in chain: req0, a=0x00010000, b=0x00000000, bin=1. Required: diff=0x0000FFFF, borrow=0.
- Contention: both valid continuously with i_res_ready=1. Required: grants go 0,1,0,1 and each result id matches its grant.
- Backpressure: i_res_ready held 0 for 3 cycles in DONE. Required: o_res_valid, diff and id stay stable, both readies stay 0, and a new accept happens only after the cycle in which i_res_ready=1 and the state has returned to IDLE.
- Reset mid-RUN (counter=2), asserted for 1 cycle. Required: next cycle state=IDLE, o_res_valid=0, o_busy=0, pointer=0. No result is emitted for the aborted operation.

Source files
------------

// File: rtl/add_sub_sched_pkg.sv
// Shared types and constants for the byte-serial subtract scheduler.
package add_sub_sched_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  typedef logic req_id_t;
endpackage

// File: rtl/add_sub_sched_slice.sv
// One byte of a borrow-chained subtractor: a - b - bin with borrow-out.
module add_sub_sched_slice
  import add_sub_sched_pkg::*;
(
  input  logic [BYTE_W-1:0] i_a,
  input  logic [BYTE_W-1:0] i_b,
  input  logic              i_bin,
  output logic [BYTE_W-1:0] o_diff,
  output logic              o_bout
);
  logic [BYTE_W:0] full;

  // Extra top bit catches the wrap-around, which is exactly the borrow-out.
  assign full   = {1'b0, i_a} - {1'b0, i_b} - {{BYTE_W{1'b0}}, i_bin};
  assign o_diff = full[BYTE_W-1:0];
  assign o_bout = full[BYTE_W];
endmodule

// File: rtl/add_sub_sub_sched.sv
// Two-requester scheduler sharing one 8-bit subtract slice; each request runs
// LSB byte first with the borrow held in a register, result on valid/ready.
module add_sub_sub_sched
  import add_sub_sched_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [DATA_W-1:0] i_req0_a,
  input  logic [DATA_W-1:0] i_req0_b,
  input  logic              i_req0_bin,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [DATA_W-1:0] i_req1_a,
  input  logic [DATA_W-1:0] i_req1_b,
  input  logic              i_req1_bin,
  output logic              o_res_valid,
  input  logic              i_res_ready,
  output logic [DATA_W-1:0] o_res_diff,
  output logic              o_res_borrow,
  output logic              o_res_id,
  output logic              o_busy
);
  localparam int NUM_BYTES = DATA_W / BYTE_W;
  localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef logic [NUM_BYTES-1:0][BYTE_W-1:0] word_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             res_valid_q, res_valid_d;
  word_t            a_q, a_d, b_q, b_d, res_q, res_d;
  req_id_t          id_q, id_d, ptr_q, ptr_d;

  req_id_t          gnt_id;
  logic             gnt_any;
  logic [BYTE_W-1:0] slice_diff;
  logic             slice_bout;

  add_sub_sched_slice u_slice (
    .i_a    (a_q[cnt_q]),
    .i_b    (b_q[cnt_q]),
    .i_bin  (borrow_q),
    .o_diff (slice_diff),
    .o_bout (slice_bout)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      borrow_q    <= 1'b0;
      res_valid_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      id_q        <= 1'b0;
      ptr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      borrow_q    <= borrow_d;
      res_valid_q <= res_valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      res_q       <= res_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
    end
  end

  // Round-robin grant: pointer only matters when both requesters contend.
  always_comb begin
    gnt_id = 1'b0;
    if (i_req0_valid && i_req1_valid) gnt_id = ptr_q;
    else if (i_req1_valid)            gnt_id = 1'b1;
    gnt_any      = (state_q == IDLE) && !i_rst && (i_req0_valid || i_req1_valid);
    o_req0_ready = gnt_any && !gnt_id;
    o_req1_ready = gnt_any && gnt_id;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    borrow_d    = borrow_q;
    res_valid_d = res_valid_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    id_d        = id_q;
    ptr_d       = ptr_q;
    case (state_q)
      IDLE: begin
        if (gnt_any) begin
          a_d      = gnt_id ? i_req1_a   : i_req0_a;
          b_d      = gnt_id ? i_req1_b   : i_req0_b;
          borrow_d = gnt_id ? i_req1_bin : i_req0_bin;
          id_d     = gnt_id;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        res_d[cnt_q] = slice_diff;
        borrow_d     = slice_bout;
        cnt_d        = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NUM_BYTES - 1)) begin
          cnt_d       = '0;
          state_d     = DONE;
          res_valid_d = 1'b1;
        end
      end
      DONE: begin
        if (i_res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
          ptr_d       = ~id_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_res_valid  = res_valid_q;
  assign o_res_diff   = res_q;
  assign o_res_borrow = borrow_q;
  assign o_res_id     = id_q;
  assign o_busy       = (state_q != IDLE);
endmodule
